tgate_bus_arbiter: RTL and testbench
====================================

// Module: tgate_bus_arbiter
//
// PURPOSE
//  Drives the control inputs of N transmission gates that share one bus line.
//  At most one gate conducts at any time. Grants rotate round-robin.
//  Every handover includes a break-before-make dead time, so two drivers never
//  fight on the bus. While all gates are off, the bus floats to 'z'.
//
// PARAMETERS
//  N         4   number of transmission gates / requesters (2..16)
//  DEAD      2   cycles all gates held off between two grants (>=1)
//  HOLD_MAX  8   max consecutive cycles one owner may hold the bus (>=1)
//
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  req        in   N          per-gate bus request, level-sensitive
//  gate_ctrl  out  N          per-gate control; 1 = gate conducts; one-hot or zero
//  grant_id   out  clog2(N)   index of current owner; holds last owner when idle
//  bus_busy   out  1          |gate_ctrl
//  timeout    out  1          1-cycle pulse when an owner is force-released at HOLD_MAX
//
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - gate_ctrl=0, grant_id=0, bus_busy=0, timeout=0.
//    - state=IDLE, rr_ptr=0, all counters 0.
//    - Asserting rst_n mid-grant drops gate_ctrl to 0 immediately (no clock needed).
//  - All outputs are registered. Invariant every cycle: gate_ctrl is one-hot or zero.
//  - Arbitration:
//    - Search starts at rr_ptr, ascending, wraps at N-1 -> 0.
//    - The first index with req=1 wins.
//  - IDLE:
//    - If |req is sampled at edge k, gate_ctrl[winner]=1 and grant_id=winner from edge k+1.
//    - Latency is 1 cycle. Go to GRANT, tenure=1.
//    - If no req, stay in IDLE with outputs unchanged.
//  - GRANT:
//    - Each cycle with req[owner]=1 and tenure<HOLD_MAX: tenure++, gate held.
//    - Release when req[owner]=0 is sampled, or when tenure==HOLD_MAX. At the next edge:
//      - gate_ctrl=0
//      - rr_ptr=(owner+1) mod N
//      - state=DEAD, dead_cnt=1
//    - The gate is high for at most HOLD_MAX cycles.
//    - timeout pulses for 1 cycle, coincident with gate_ctrl falling, only on a forced
//      release: tenure==HOLD_MAX while req[owner] is still 1.
//    - If req drops on the same cycle tenure hits HOLD_MAX, it is a normal release
//      and timeout stays 0.
//    - Requests from other gates never pre-empt the owner.
//  - DEAD:
//    - gate_ctrl=0 for exactly DEAD cycles. dead_cnt counts 1..DEAD.
//    - On the cycle dead_cnt==DEAD, arbitration is evaluated as in IDLE:
//      - winner found -> GRANT at the next edge
//      - no winner -> IDLE
//    - With continuous requests, the gap between grants is exactly DEAD cycles of all-zero.
//  - Released owner: has lowest priority in the next arbitration (rotated pointer).
//    If it is the only requester, it wins again after the dead time.
//  - req bits for gates not owning the bus may toggle freely; only levels at the
//    arbitration cycle matter. No request latching.
//  - tenure and dead_cnt widths: clog2(HOLD_MAX+1) and clog2(DEAD+1). No wrap is possible.
//
// TESTING  (N=4, DEAD=2, HOLD_MAX=8; clk period 10)
//  1 Reset, req=0000 for 5 cycles -> gate_ctrl=0000, bus_busy=0, grant_id=0, timeout=0.
//  2 req=0100 set at edge k, dropped after 3 cycles
//    -> gate_ctrl=0100 from edge k+1 for 3 cycles, then 0000 for >=2 cycles,
//       then IDLE; grant_id=2 throughout.
//  3 req=1111 held constant
//    -> grant order 0,1,2,3,0; each held 8 cycles; timeout pulse on each release;
//       exactly 2 zero cycles between grants; gate_ctrl never has 2 bits set.
//  4 req=0001 held -> grant 0 for 8 cycles, timeout=1, 2 dead cycles, grant 0 again
//    (sole requester).
//  5 Owner 1 granted; rst_n=0 asynchronously mid-cycle
//    -> gate_ctrl=0000 before the next clk edge; after release, arbitration
//       restarts at index 0.
//  6 Owner 3 drops req on the same cycle tenure hits 8, req[0]=1
//    -> timeout stays 0, rr_ptr=0, grant 0 after 2 dead cycles.
//  All tests: an assertion checks one-hot-or-zero on gate_ctrl every cycle, and a
//  model of the shared line checks it is 'z' whenever gate_ctrl=0.

Source files
------------

// File: rtl/tgate_bus_arbiter_if.sv
// Bundle of request/gate-control signals between the arbiter and the transmission gates.
// The arbiter drives gate controls and status; requesters drive req.
interface tgate_bus_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gate_ctrl;
  logic [IW-1:0] grant_id;
  logic          bus_busy;
  logic          timeout;

  modport master (
    input  req,
    output gate_ctrl,
    output grant_id,
    output bus_busy,
    output timeout
  );

  modport slave (
    output req,
    input  gate_ctrl,
    input  grant_id,
    input  bus_busy,
    input  timeout
  );
endinterface

// File: rtl/tgate_bus_arbiter.sv
// Round-robin owner selection for N transmission gates sharing one line, with a
// break-before-make dead time between owners and a forced release after HOLD_MAX cycles.
module tgate_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEAD     = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tgate_bus_arbiter_if.master  bus
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = $clog2(HOLD_MAX + 1);
  localparam int unsigned DW = $clog2(DEAD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_owner;
  logic [TW-1:0] r_tenure;
  logic [DW-1:0] r_dead_cnt;
  logic [N-1:0]  r_gate;
  logic          r_busy;
  logic          r_timeout;

  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [N-1:0]  w_grant_vec;
  logic          w_owner_req;
  logic [IW-1:0] w_next_ptr;

  // First requester at or after r_rr_ptr, wrapping at N-1.
  always_comb begin : rr_search
    logic [IW:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (IW+1)'(r_rr_ptr) + (IW+1)'(i);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!w_found && bus.req[idx[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_grant_vec           = '0;
    w_grant_vec[w_winner] = 1'b1;
  end

  assign w_owner_req = bus.req[r_owner];
  assign w_next_ptr  = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_tenure   <= '0;
      r_dead_cnt <= '0;
      r_gate     <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_GRANT;
            r_owner  <= w_winner;
            r_gate   <= w_grant_vec;
            r_busy   <= 1'b1;
            r_tenure <= TW'(1);
          end
        end
        S_GRANT: begin
          // Voluntary drop and forced release both open a dead window; only the latter flags timeout.
          if (!w_owner_req || (r_tenure == TW'(HOLD_MAX))) begin
            r_state    <= S_DEAD;
            r_gate     <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= w_owner_req;
            r_rr_ptr   <= w_next_ptr;
            r_tenure   <= '0;
            r_dead_cnt <= DW'(1);
          end else begin
            r_tenure <= r_tenure + TW'(1);
          end
        end
        S_DEAD: begin
          if (r_dead_cnt == DW'(DEAD)) begin
            r_dead_cnt <= '0;
            if (w_found) begin
              r_state  <= S_GRANT;
              r_owner  <= w_winner;
              r_gate   <= w_grant_vec;
              r_busy   <= 1'b1;
              r_tenure <= TW'(1);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + DW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gate  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_ctrl = r_gate;
  assign bus.grant_id  = r_owner;
  assign bus.bus_busy  = r_busy;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected grant tenures, a negedge monitor
// matches each observed grant/release against them and models the shared line.
module tb_tgate_bus_arbiter;

  localparam int N      = 4;
  localparam int LINE_Z = 2;
  localparam int LINE_X = 3;

  typedef struct {
    int id;
    int len;   // -1: not checked
    int to;
    int gap;   // -1: not checked
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tgate_bus_arbiter_if #(.N(N)) bus_if ();

  tgate_bus_arbiter #(.N(N), .DEAD(2), .HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  exp_t   q[$];
  exp_t   cur;
  int     checks   = 0;
  int     failures = 0;
  logic [N-1:0] prev_gate = '0;
  bit     active   = 1'b0;
  int     hi_cnt   = 0;
  int     zero_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Shared line: gate i passes driver value i%2; no conducting gate leaves it floating.
  function automatic int line_of(input logic [N-1:0] g);
    int v;
    v = LINE_Z;
    for (int i = 0; i < N; i++) begin
      if (g[i]) v = (v == LINE_Z) ? (i % 2) : LINE_X;
    end
    return v;
  endfunction

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus_if.gate_ctrl));

  always @(negedge clk) begin
    logic [N-1:0] g;
    g = bus_if.gate_ctrl;
    if (!rst_n) begin
      prev_gate = '0;
      active    = 1'b0;
      zero_cnt  = 0;
    end else begin
      check("onehot0", int'($onehot0(g)), 1);
      check("bus_busy", int'(bus_if.bus_busy), int'(|g));
      if (g == '0) check("line_z", line_of(g), LINE_Z);
      else         check("line_val", line_of(g), int'(bus_if.grant_id) % 2);
      if (g != '0 && prev_gate == '0) begin
        if (q.size() == 0) begin
          check("unexpected_grant", int'(g), 0);
        end else begin
          cur    = q.pop_front();
          active = 1'b1;
          hi_cnt = 1;
          check("grant_vec", int'(g), 1 << cur.id);
          check("grant_id", int'(bus_if.grant_id), cur.id);
          if (cur.gap >= 0) check("dead_gap", zero_cnt, cur.gap);
        end
        check("timeout_on_grant", int'(bus_if.timeout), 0);
      end else if (g != '0) begin
        hi_cnt++;
        check("owner_stable", int'(g), int'(prev_gate));
        check("timeout_mid", int'(bus_if.timeout), 0);
      end else if (prev_gate != '0) begin
        if (active) begin
          if (cur.len >= 0) check("hold_len", hi_cnt, cur.len);
          check("timeout_release", int'(bus_if.timeout), cur.to);
        end
        active   = 1'b0;
        zero_cnt = 1;
      end else begin
        zero_cnt++;
        check("timeout_idle", int'(bus_if.timeout), 0);
      end
      prev_gate = g;
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_if.req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || active) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, int'(q.size() != 0 || active), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.req = '0;

    // 1: reset holds everything off
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t1_gate", int'(bus_if.gate_ctrl), 0);
      check("t1_busy", int'(bus_if.bus_busy), 0);
      check("t1_grant_id", int'(bus_if.grant_id), 0);
      check("t1_timeout", int'(bus_if.timeout), 0);
    end
    #2 rst_n = 1'b1;
    edges(2);

    // 2: single short request, then idle with grant_id retained
    q.push_back('{2, 3, 0, -1});
    bus_if.req = 4'b0100;
    edges(1);
    check("t2_latency", int'(bus_if.gate_ctrl), 4'b0100);
    edges(2);
    bus_if.req = 4'b0000;
    edges(4);
    check("t2_idle_gate", int'(bus_if.gate_ctrl), 0);
    check("t2_idle_id", int'(bus_if.grant_id), 2);
    wait_drain("t2", 20);

    // 3: all request continuously -> rotation with forced releases
    do_reset();
    q.push_back('{0, 8, 1, -1});
    q.push_back('{1, 8, 1, 2});
    q.push_back('{2, 8, 1, 2});
    q.push_back('{3, 8, 1, 2});
    q.push_back('{0, 8, 1, 2});
    bus_if.req = 4'b1111;
    wait_drain("t3", 80);
    bus_if.req = 4'b0000;
    edges(4);

    // 4: sole requester regains the bus after the dead time
    do_reset();
    q.push_back('{0, 8, 1, -1});
    q.push_back('{0, 8, 1, 2});
    bus_if.req = 4'b0001;
    wait_drain("t4", 40);
    bus_if.req = 4'b0000;
    edges(4);

    // 5: async reset mid-grant, pointer returns to 0
    do_reset();
    q.push_back('{1, 2, 0, -1});
    bus_if.req = 4'b0010;
    edges(2);
    bus_if.req = 4'b0000;
    edges(4);
    q.push_back('{1, -1, 0, -1});
    bus_if.req = 4'b0010;
    edges(3);
    check("t5_pre_reset", int'(bus_if.gate_ctrl), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_gate", int'(bus_if.gate_ctrl), 0);
    check("t5_async_busy", int'(bus_if.bus_busy), 0);
    check("t5_async_id", int'(bus_if.grant_id), 0);
    bus_if.req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #2;
    q.push_back('{1, 3, 0, -1});
    bus_if.req = 4'b0110;
    rst_n = 1'b1;
    edges(3);
    bus_if.req = 4'b0000;
    wait_drain("t5", 20);
    edges(3);

    // 6: owner drops req exactly at HOLD_MAX -> normal release, no timeout
    do_reset();
    q.push_back('{3, 8, 0, -1});
    q.push_back('{0, 3, 0, 2});
    bus_if.req = 4'b1000;
    edges(1);
    bus_if.req = 4'b1001;
    edges(7);
    bus_if.req = 4'b0001;
    edges(5);
    bus_if.req = 4'b0000;
    wait_drain("t6", 20);
    edges(4);

    check("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
